// File: rtl/tmma_pe_seq_pkg.sv
// Shared widths, FSM state encoding and helpers for the TMMA PE sequencer.
// State encoding is fixed so the tile scheduler can decode busy state directly.
`ifndef PE_INPUT_DATA_WIDTH
`define PE_INPUT_DATA_WIDTH 16
`endif
`ifndef TMMA_PRECISION_WIDTH
`define TMMA_PRECISION_WIDTH 3
`endif

package tmma_pe_seq_pkg;
  localparam int DW     = `PE_INPUT_DATA_WIDTH;
  localparam int PW     = `TMMA_PRECISION_WIDTH;
  localparam int PERF_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOADC = 2'd1,
    ST_CALC  = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_t;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/tmma_pe_seq_if.sv
// Handshake and operand bundle between scheduler/operand buffers, the sequencer and the mac.
// slave is the sequencer's view; master is the requester/mac side.
interface tmma_pe_seq_if #(parameter int K_W = 8);
  import tmma_pe_seq_pkg::*;

  logic           cmd_valid;
  logic           cmd_ready;
  logic [K_W-1:0] cmd_k;
  logic [PW-1:0]  cmd_prec;
  logic           cmd_cinit;

  logic           c_valid;
  logic           c_ready;
  logic [DW-1:0]  c_data;

  logic           ab_valid;
  logic           ab_ready;
  logic [DW-1:0]  a_data;
  logic [DW-1:0]  b_data;

  logic           mac_c_valid;
  logic [DW-1:0]  mac_c_data;
  logic           mac_cal_valid;
  logic [PW-1:0]  mac_cal_precision;
  logic [DW-1:0]  mac_a_data;
  logic [DW-1:0]  mac_b_data;
  logic [DW-1:0]  mac_d_data;

  logic           d_valid;
  logic           d_ready;
  logic [DW-1:0]  d_data;
  logic           busy;

  modport slave (
    input  cmd_valid, cmd_k, cmd_prec, cmd_cinit,
    input  c_valid, c_data, ab_valid, a_data, b_data,
    input  mac_d_data, d_ready,
    output cmd_ready, c_ready, ab_ready,
    output mac_c_valid, mac_c_data, mac_cal_valid, mac_cal_precision, mac_a_data, mac_b_data,
    output d_valid, d_data, busy
  );

  modport master (
    output cmd_valid, cmd_k, cmd_prec, cmd_cinit,
    output c_valid, c_data, ab_valid, a_data, b_data,
    output mac_d_data, d_ready,
    input  cmd_ready, c_ready, ab_ready,
    input  mac_c_valid, mac_c_data, mac_cal_valid, mac_cal_precision, mac_a_data, mac_b_data,
    input  d_valid, d_data, busy
  );
endinterface

// File: rtl/tmma_pe_seq.sv
// Sequences one mac op: load C, stream K A/B pairs, return result; accept->d_valid is K+2 cycles.
// Optional TMMA_SEQ_PERF_EN adds perf_stall, a saturating count of CALC/DRAIN stall cycles.
module tmma_pe_seq
  import tmma_pe_seq_pkg::*;
#(
  parameter int K_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  tmma_pe_seq_if.slave        bus
`ifdef TMMA_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0]   perf_stall
`endif
);

  seq_state_t     state;
  logic [K_W-1:0] k_rem;
  logic [PW-1:0]  prec;
  logic           cinit;

  logic in_idle, in_loadc, in_calc, in_drain;
  logic cmd_acc, ab_acc;

  assign in_idle  = (state == ST_IDLE);
  assign in_loadc = (state == ST_LOADC);
  assign in_calc  = (state == ST_CALC);
  assign in_drain = (state == ST_DRAIN);
  assign cmd_acc  = in_idle & bus.cmd_valid;
  assign ab_acc   = in_calc & bus.ab_valid;

  assign bus.cmd_ready = in_idle;
  assign bus.busy      = ~in_idle;

  // Zero-init of C is a single forced pulse; with cinit the mac sees the c stream directly.
  assign bus.c_ready     = in_loadc & cinit;
  assign bus.mac_c_valid = in_loadc & (cinit ? bus.c_valid : 1'b1);
  assign bus.mac_c_data  = (in_loadc & cinit) ? bus.c_data : '0;

  assign bus.ab_ready          = in_calc;
  assign bus.mac_cal_valid     = ab_acc;
  assign bus.mac_cal_precision = prec;
  assign bus.mac_a_data        = bus.a_data;
  assign bus.mac_b_data        = bus.b_data;

  assign bus.d_valid = in_drain;
  assign bus.d_data  = bus.mac_d_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      k_rem <= '0;
      prec  <= '0;
      cinit <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            k_rem <= bus.cmd_k;
            prec  <= bus.cmd_prec;
            cinit <= bus.cmd_cinit;
            state <= ST_LOADC;
          end
        end
        ST_LOADC: begin
          if (!cinit || bus.c_valid) begin
            state <= (k_rem == '0) ? ST_DRAIN : ST_CALC;
          end
        end
        ST_CALC: begin
          if (bus.ab_valid) begin
            if (k_rem != '0) begin
              k_rem <= k_rem - 1'b1;
            end
            if (k_rem <= K_W'(1)) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.d_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef TMMA_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || cmd_acc) begin
      perf_stall <= '0;
    end else if ((in_calc && !bus.ab_valid) || (in_drain && !bus.d_ready)) begin
      perf_stall <= sat_inc(perf_stall);
    end
  end
`endif

endmodule

// File: tb/tb_tmma_pe_seq.sv
// Bench for tmma_pe_seq with a fake mac (result = a+b of the last cal step, or loaded C).
// Results are checked through a scoreboard queue plus per-scenario timing/pulse checks.
module tb_tmma_pe_seq;
  import tmma_pe_seq_pkg::*;

  localparam int K_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tmma_pe_seq_if #(.K_W(K_W)) bus();

`ifdef TMMA_SEQ_PERF_EN
  logic [PERF_W-1:0] perf_stall;
`endif

  tmma_pe_seq #(.K_W(K_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef TMMA_SEQ_PERF_EN
    ,
    .perf_stall (perf_stall)
`endif
  );

  logic [DW-1:0] mac_d;
  always @(posedge clk) begin
    if (rst) mac_d <= '0;
    else if (bus.mac_c_valid) mac_d <= bus.mac_c_data;
    else if (bus.mac_cal_valid) mac_d <= bus.mac_a_data + bus.mac_b_data;
  end
  assign bus.mac_d_data = mac_d;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cal_cnt = 0;
  int czero_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pa[256];
  logic [DW-1:0] pb[256];

  always @(posedge clk) cyc <= cyc + 1;

  // Global monitor: scoreboard, mac valid exclusivity, precision stability during an op.
  initial begin
    logic          busy_q;
    logic [PW-1:0] prec_q;
    logic [DW-1:0] exp_d;
    busy_q = 1'b0;
    prec_q = '0;
    forever begin
      @(negedge clk);
      if (bus.mac_cal_valid) cal_cnt++;
      if (bus.mac_c_valid && bus.mac_c_data == '0) czero_cnt++;
      if (!rst && bus.busy) begin
        checks++;
        if (bus.mac_c_valid && bus.mac_cal_valid) begin
          errors++;
          $display("FAIL mac_valid_overlap: c_valid=%0b cal_valid=%0b, required not both high",
                   bus.mac_c_valid, bus.mac_cal_valid);
        end
        if (busy_q) begin
          checks++;
          if (bus.mac_cal_precision !== prec_q) begin
            errors++;
            $display("FAIL prec_stable: got %0h, required %0h", bus.mac_cal_precision, prec_q);
          end
        end
      end
      if (!rst && bus.d_valid && bus.d_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_unexpected: d_data=%0h with no expected result", bus.d_data);
        end else begin
          exp_d = exp_q.pop_front();
          if (bus.d_data !== exp_d) begin
            errors++;
            $display("FAIL scoreboard_d_data: got %0h, required %0h", bus.d_data, exp_d);
          end
        end
      end
      busy_q = rst ? 1'b0 : bus.busy;
      prec_q = bus.mac_cal_precision;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0;
    bus.cmd_k     = '0;
    bus.cmd_prec  = '0;
    bus.cmd_cinit = 1'b0;
    bus.c_valid   = 1'b0;
    bus.c_data    = '0;
    bus.ab_valid  = 1'b0;
    bus.a_data    = '0;
    bus.b_data    = '0;
    bus.d_ready   = 1'b0;
  endtask

  // Drives one full command; stall_after/stall_len hold ab_valid low after that many pairs.
  task automatic run_op(input int k, input bit cinit, input logic [DW-1:0] cval,
                        input logic [PW-1:0] prec, input int stall_after, input int stall_len,
                        input int dhold, input bit hold_cmd,
                        output int lat, output int rdy_hi, output int dchg);
    int idx, scnt, dwait, acc, guard;
    bit accepted, c_done, d_seen, done;
    logic [DW-1:0] d0;
    idx = 0; scnt = 0; dwait = 0; acc = 0; guard = 0;
    accepted = 0; c_done = 0; d_seen = 0; done = 0; d0 = '0;
    lat = -1; rdy_hi = 0; dchg = 0;
    if (k == 0) exp_q.push_back(cinit ? cval : '0);
    else exp_q.push_back(pa[k-1] + pb[k-1]);
    @(posedge clk); #1;
    cal_cnt = 0;
    czero_cnt = 0;
    while (!done && guard < 3000) begin
      bus.cmd_valid = !accepted || hold_cmd;
      bus.cmd_k     = K_W'(k);
      bus.cmd_prec  = prec;
      bus.cmd_cinit = cinit;
      bus.c_valid   = cinit && !c_done;
      bus.c_data    = cval;
      bus.ab_valid  = (idx < k) && !(idx == stall_after && scnt < stall_len);
      bus.a_data    = (idx < k) ? pa[idx] : '0;
      bus.b_data    = (idx < k) ? pb[idx] : '0;
      bus.d_ready   = (dwait >= dhold);
      @(negedge clk);
      if (bus.cmd_valid && bus.cmd_ready && !accepted) begin
        accepted = 1;
        acc = cyc;
      end else if (accepted && bus.cmd_ready) begin
        rdy_hi++;
      end
      if (bus.c_valid && bus.c_ready) c_done = 1;
      if (bus.ab_ready && !bus.ab_valid && idx == stall_after) scnt++;
      if (bus.ab_valid && bus.ab_ready) idx++;
      if (bus.d_valid) begin
        if (!d_seen) begin
          d_seen = 1;
          lat = cyc - acc;
          d0 = bus.d_data;
        end else if (bus.d_data !== d0) begin
          dchg++;
        end
        if (!bus.d_ready) dwait++;
        else done = 1;
      end
      @(posedge clk); #1;
      guard++;
    end
    idle_inputs();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: k=%0d no result handshake within %0d cycles", k, guard);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b, required 1", bus.cmd_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, required 0", bus.busy); end
    checks++; if (bus.c_ready !== 1'b0) begin errors++; $display("FAIL reset_c_ready: got %0b, required 0", bus.c_ready); end
    checks++; if (bus.ab_ready !== 1'b0) begin errors++; $display("FAIL reset_ab_ready: got %0b, required 0", bus.ab_ready); end
    checks++; if (bus.d_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid: got %0b, required 0", bus.d_valid); end
    checks++; if (bus.mac_c_valid !== 1'b0) begin errors++; $display("FAIL reset_mac_c_valid: got %0b, required 0", bus.mac_c_valid); end
    checks++; if (bus.mac_cal_valid !== 1'b0) begin errors++; $display("FAIL reset_mac_cal_valid: got %0b, required 0", bus.mac_cal_valid); end
    checks++; if (bus.mac_cal_precision !== '0) begin errors++; $display("FAIL reset_prec: got %0h, required 0", bus.mac_cal_precision); end
`ifdef TMMA_SEQ_PERF_EN
    checks++; if (perf_stall !== '0) begin errors++; $display("FAIL reset_perf: got %0d, required 0", perf_stall); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, rdy_hi, dchg;
    pa[0] = 16'd1;  pb[0] = 16'd2;
    pa[1] = 16'd3;  pb[1] = 16'd4;
    pa[2] = 16'd10; pb[2] = 16'd20;
    run_op(3, 1'b1, 16'd5, 3'd1, 999, 0, 0, 1'b0, lat, rdy_hi, dchg);
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d, required 5", lat); end
    checks++; if (cal_cnt !== 3) begin errors++; $display("FAIL basic_cal_pulses: got %0d, required 3", cal_cnt); end
  endtask

  task automatic test_k_zero();
    int lat, rdy_hi, dchg;
    run_op(0, 1'b1, 16'h1234, 3'd2, 999, 0, 0, 1'b0, lat, rdy_hi, dchg);
    checks++; if (lat !== 2) begin errors++; $display("FAIL kzero_latency: got %0d, required 2", lat); end
    checks++; if (cal_cnt !== 0) begin errors++; $display("FAIL kzero_cal_pulses: got %0d, required 0", cal_cnt); end
  endtask

  task automatic test_stall();
    int lat, rdy_hi, dchg;
    pa[0] = 16'd100; pb[0] = 16'd1;
    pa[1] = 16'd6;   pb[1] = 16'd9;
    run_op(2, 1'b0, 16'hBEEF, 3'd5, 1, 4, 0, 1'b0, lat, rdy_hi, dchg);
    checks++; if (czero_cnt !== 1) begin errors++; $display("FAIL stall_c_zero_pulses: got %0d, required 1", czero_cnt); end
    checks++; if (cal_cnt !== 2) begin errors++; $display("FAIL stall_cal_pulses: got %0d, required 2", cal_cnt); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL stall_latency: got %0d, required 8", lat); end
`ifdef TMMA_SEQ_PERF_EN
    checks++; if (perf_stall !== 16'd4) begin errors++; $display("FAIL stall_perf: got %0d, required 4", perf_stall); end
`endif
  endtask

  task automatic test_drain_hold();
    int lat, rdy_hi, dchg;
    pa[0] = 16'h40; pb[0] = 16'h2;
    run_op(1, 1'b1, 16'h7, 3'd3, 999, 0, 3, 1'b1, lat, rdy_hi, dchg);
    checks++; if (rdy_hi !== 0) begin errors++; $display("FAIL hold_cmd_ready: high for %0d cycles before d handshake, required 0", rdy_hi); end
    checks++; if (dchg !== 0) begin errors++; $display("FAIL hold_d_stable: changed %0d times, required 0", dchg); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL hold_latency: got %0d, required 3", lat); end
`ifdef TMMA_SEQ_PERF_EN
    checks++; if (perf_stall !== 16'd3) begin errors++; $display("FAIL hold_perf: got %0d, required 3", perf_stall); end
`endif
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL hold_cmd_ready_after: got %0b, required 1", bus.cmd_ready); end
  endtask

  task automatic test_max_k();
    int lat, rdy_hi, dchg;
    for (int i = 0; i < 256; i++) begin
      pa[i] = DW'(i);
      pb[i] = DW'(2 * i);
    end
    run_op(255, 1'b0, '0, 3'd7, 999, 0, 0, 1'b0, lat, rdy_hi, dchg);
    checks++; if (lat !== 257) begin errors++; $display("FAIL maxk_latency: got %0d, required 257", lat); end
    checks++; if (cal_cnt !== 255) begin errors++; $display("FAIL maxk_cal_pulses: got %0d, required 255", cal_cnt); end
  endtask

  task automatic test_reset_mid();
    int lat, rdy_hi, dchg, n, guard;
    n = 0; guard = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_k     = K_W'(5);
    bus.cmd_prec  = 3'd6;
    bus.cmd_cinit = 1'b0;
    bus.ab_valid  = 1'b1;
    bus.a_data    = 16'd1;
    bus.b_data    = 16'd1;
    while (n < 2 && guard < 50) begin
      @(negedge clk);
      if (bus.ab_valid && bus.ab_ready) n++;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      guard++;
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL midrst_steps: got %0d handshakes, required 2", n); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b, required 0", bus.busy); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_cmd_ready: got %0b, required 1", bus.cmd_ready); end
    checks++; if (bus.ab_ready !== 1'b0) begin errors++; $display("FAIL midrst_ab_ready: got %0b, required 0", bus.ab_ready); end
    checks++; if (bus.d_valid !== 1'b0) begin errors++; $display("FAIL midrst_d_valid: got %0b, required 0", bus.d_valid); end
    checks++; if (bus.mac_c_valid !== 1'b0) begin errors++; $display("FAIL midrst_mac_c_valid: got %0b, required 0", bus.mac_c_valid); end
    pa[0] = 16'd7; pb[0] = 16'd8;
    run_op(1, 1'b1, 16'h55, 3'd4, 999, 0, 0, 1'b0, lat, rdy_hi, dchg);
    checks++; if (lat !== 3) begin errors++; $display("FAIL midrst_next_latency: got %0d, required 3", lat); end
    checks++; if (cal_cnt !== 1) begin errors++; $display("FAIL midrst_next_cal_pulses: got %0d, required 1", cal_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_k_zero();
    test_stall();
    test_drain_hold();
    test_max_k();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d results not produced, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
